// File: rtl/matmul_seq_engine_pkg.sv
// Shared definitions for the sequential matrix-multiply engine:
// FSM state encoding, counter sizing helper and the output saturation rule.
package matmul_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Counter width for a dimension; a dimension of 1 still needs one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // Clamp an accumulator (pre-extended to 128 bits by the caller) into the
  // signed or unsigned range of an out_width-bit result.
  function automatic logic [127:0] saturate(input logic [127:0] acc,
                                            input int out_width,
                                            input logic is_signed,
                                            output logic clipped);
    logic [127:0] one_v;
    logic [127:0] max_v;
    logic [127:0] min_v;
    logic [127:0] result;
    one_v   = 128'd1;
    clipped = 1'b0;
    result  = acc;
    if (is_signed) begin
      max_v = (one_v << (out_width - 1)) - one_v;
      min_v = ~max_v;
      if ($signed(acc) > $signed(max_v)) begin
        result  = max_v;
        clipped = 1'b1;
      end else if ($signed(acc) < $signed(min_v)) begin
        result  = min_v;
        clipped = 1'b1;
      end
    end else begin
      max_v = (one_v << out_width) - one_v;
      if (acc > max_v) begin
        result  = max_v;
        clipped = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/matmul_seq_engine_if.sv
// Operand, result and handshake bundle between the operand buffers / result
// consumer (master) and the matrix-multiply engine (slave).
interface matmul_seq_engine_if #(
  parameter int M         = 4,
  parameter int P         = 4,
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 32
);
  logic [0:M*P*WIDTH-1]     matrix_A;
  logic [0:P*N*WIDTH-1]     matrix_B;
  logic                     a_stb;
  logic                     b_stb;
  logic                     signed_mode;
  logic                     acc_en;
  logic                     c_ack;
  logic                     a_ack;
  logic                     b_ack;
  logic [0:M*N*OUT_WIDTH-1] matrix_C;
  logic                     c_stb;
  logic                     busy;
  logic                     overflow;

  modport master (
    output matrix_A, matrix_B, a_stb, b_stb, signed_mode, acc_en, c_ack,
    input  a_ack, b_ack, matrix_C, c_stb, busy, overflow
  );

  modport slave (
    input  matrix_A, matrix_B, a_stb, b_stb, signed_mode, acc_en, c_ack,
    output a_ack, b_ack, matrix_C, c_stb, busy, overflow
  );
endinterface

// File: rtl/matmul_seq_engine_mac_unit.sv
// Shared multiply-accumulate datapath: one signed or unsigned product per
// cycle, either loaded on top of an initial value or added to the running sum.
module mac_unit #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 36
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 en,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [ACC_WIDTH-1:0] init,
  output logic [ACC_WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0]   prod;
  logic [ACC_WIDTH-1:0] prod_ext;

  // Extending both operands by their mode-dependent MSB makes the low 2*WIDTH
  // bits of one multiplier correct for both signed and unsigned operands.
  always_comb begin
    prod = {{WIDTH{signed_mode & a[WIDTH-1]}}, a} *
           {{WIDTH{signed_mode & b[WIDTH-1]}}, b};
    prod_ext = {{(ACC_WIDTH-2*WIDTH){signed_mode & prod[2*WIDTH-1]}}, prod};
  end

  // Accumulator register: load starts a new element, en continues it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       acc <= '0;
    else if (clear) acc <= '0;
    else if (load)  acc <= init + prod_ext;
    else if (en)    acc <= acc + prod_ext;
  end

endmodule

// File: rtl/matmul_seq_engine.sv
// Sequential C = A x B (or C += A x B) engine: walks every (i,j) element,
// spends P cycles accumulating the inner product on one MAC and a write
// cycle saturating it into the retained C register.
module matmul_seq_engine
  import matmul_pkg::*;
#(
  parameter int M         = 4,
  parameter int P         = 4,
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 32,
  parameter int ACC_WIDTH = 2*WIDTH + $clog2(P) + 2
) (
  input logic clk,
  input logic rst,
  matmul_seq_engine_if.slave bus
);

  localparam int IW = clog2_min1(M);
  localparam int JW = clog2_min1(N);
  localparam int KW = clog2_min1(P);

  logic [1:0]               state;
  logic [IW-1:0]            row;
  logic [JW-1:0]            col;
  logic [KW-1:0]            step;
  logic [0:M*P*WIDTH-1]     a_reg;
  logic [0:P*N*WIDTH-1]     b_reg;
  logic [0:M*N*OUT_WIDTH-1] c_reg;
  logic                     sm_reg;
  logic                     ae_reg;
  logic                     ovf;
  logic                     a_ack_r;
  logic                     b_ack_r;

  logic                     start;
  logic [WIDTH-1:0]         a_elem;
  logic [WIDTH-1:0]         b_elem;
  logic [OUT_WIDTH-1:0]     c_old;
  logic [ACC_WIDTH-1:0]     init_val;
  logic [ACC_WIDTH-1:0]     acc;
  logic [OUT_WIDTH-1:0]     sat_val;
  logic                     clipped;

  assign start = (state == S_IDLE) && bus.a_stb && bus.b_stb;

  // Pick the operands and previous result for the current (i,j,k) position.
  always_comb begin
    a_elem   = a_reg[(int'(row)*P + int'(step))*WIDTH +: WIDTH];
    b_elem   = b_reg[(int'(step)*N + int'(col))*WIDTH +: WIDTH];
    c_old    = c_reg[(int'(row)*N + int'(col))*OUT_WIDTH +: OUT_WIDTH];
    init_val = '0;
    if (ae_reg)
      init_val = {{(ACC_WIDTH-OUT_WIDTH){sm_reg & c_old[OUT_WIDTH-1]}}, c_old};
  end

  mac_unit #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk         (clk),
    .rst         (rst),
    .clear       (start),
    .load        ((state == S_MAC) && (step == '0)),
    .en          (state == S_MAC),
    .signed_mode (sm_reg),
    .a           (a_elem),
    .b           (b_elem),
    .init        (init_val),
    .acc         (acc)
  );

  // Clamp the finished inner product into the C element range.
  always_comb begin
    clipped = 1'b0;
    sat_val = OUT_WIDTH'(saturate({{(128-ACC_WIDTH){sm_reg & acc[ACC_WIDTH-1]}}, acc},
                                  OUT_WIDTH, sm_reg, clipped));
  end

  // Job sequencing: capture, per-element MAC/WRITE walk, then hold until acked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      step    <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      c_reg   <= '0;
      sm_reg  <= 1'b0;
      ae_reg  <= 1'b0;
      ovf     <= 1'b0;
      a_ack_r <= 1'b0;
      b_ack_r <= 1'b0;
    end else begin
      a_ack_r <= 1'b0;
      b_ack_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg   <= bus.matrix_A;
            b_reg   <= bus.matrix_B;
            sm_reg  <= bus.signed_mode;
            ae_reg  <= bus.acc_en;
            a_ack_r <= 1'b1;
            b_ack_r <= 1'b1;
            ovf     <= 1'b0;
            row     <= '0;
            col     <= '0;
            step    <= '0;
            state   <= S_MAC;
          end
        end
        S_MAC: begin
          if (step == KW'(P-1)) begin
            step  <= '0;
            state <= S_WRITE;
          end else begin
            step <= step + 1'b1;
          end
        end
        S_WRITE: begin
          c_reg[(int'(row)*N + int'(col))*OUT_WIDTH +: OUT_WIDTH] <= sat_val;
          if (clipped) ovf <= 1'b1;
          state <= S_MAC;
          if (col == JW'(N-1)) begin
            col <= '0;
            if (row == IW'(M-1)) begin
              row   <= '0;
              state <= S_DONE;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        default: begin
          if (bus.c_ack) state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.a_ack    = a_ack_r;
  assign bus.b_ack    = b_ack_r;
  assign bus.matrix_C = c_reg;
  assign bus.c_stb    = (state == S_DONE);
  assign bus.busy     = (state != S_IDLE);
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_matmul_seq_engine.sv
// Bench for matmul_seq_engine: a 2x2x2 engine exercised with directed and
// random jobs against an integer reference model, plus a 1x1x1 engine.
module tb_matmul_seq_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2;
  logic rst1;
  int tests = 0;
  int fails = 0;

  int a_m[2][2];
  int b_m[2][2];
  int c_model[2][2];
  int c_next[2][2];
  bit ovf_exp;

  matmul_seq_engine_if #(.M(2), .P(2), .N(2), .WIDTH(8), .OUT_WIDTH(16)) bus2();
  matmul_seq_engine_if #(.M(1), .P(1), .N(1), .WIDTH(8), .OUT_WIDTH(16)) bus1();

  matmul_seq_engine #(.M(2), .P(2), .N(2), .WIDTH(8), .OUT_WIDTH(16), .ACC_WIDTH(18)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  matmul_seq_engine #(.M(1), .P(1), .N(1), .WIDTH(8), .OUT_WIDTH(16), .ACC_WIDTH(18)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raw bit pattern to integer value under the job's signedness.
  function automatic longint ival(input int raw, input int bits, input bit sm);
    if (sm && raw >= (1 << (bits - 1))) return longint'(raw) - (longint'(1) << bits);
    return longint'(raw);
  endfunction

  // Reference: plain integer matrix product, optional accumulate, clamp.
  task automatic model_job(input bit sm, input bit ae);
    longint s;
    longint lo;
    longint hi;
    ovf_exp = 1'b0;
    lo = sm ? -32768 : 0;
    hi = sm ? 32767 : 65535;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = ae ? ival(c_model[i][j], 16, sm) : 0;
        for (int k = 0; k < 2; k++)
          s += ival(a_m[i][k], 8, sm) * ival(b_m[k][j], 8, sm);
        if (s > hi) begin s = hi; ovf_exp = 1'b1; end
        else if (s < lo) begin s = lo; ovf_exp = 1'b1; end
        c_next[i][j] = int'(s & 64'hFFFF);
      end
    end
  endtask

  task automatic pack_ops();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++) begin
        bus2.matrix_A[(i*2+k)*8 +: 8] = 8'(a_m[i][k]);
        bus2.matrix_B[(i*2+k)*8 +: 8] = 8'(b_m[i][k]);
      end
  endtask

  task automatic set_ops(input int a00, a01, a10, a11, b00, b01, b10, b11);
    a_m[0][0] = a00; a_m[0][1] = a01; a_m[1][0] = a10; a_m[1][1] = a11;
    b_m[0][0] = b00; b_m[0][1] = b01; b_m[1][0] = b10; b_m[1][1] = b11;
  endtask

  // One full job on the 2x2x2 engine; called at a negedge with the engine idle.
  task automatic run_job(input string name, input bit sm, input bit ae,
                         input bit hold, input int stall);
    int extra;
    int early;
    int unstable;
    logic [0:63] snap;
    logic [15:0] elem;
    model_job(sm, ae);
    pack_ops();
    bus2.signed_mode = sm;
    bus2.acc_en      = ae;
    bus2.a_stb       = 1'b1;
    bus2.b_stb       = 1'b1;
    @(negedge clk);
    check({name, " a_ack"}, 64'(bus2.a_ack), 64'd1);
    check({name, " b_ack"}, 64'(bus2.b_ack), 64'd1);
    if (!hold) begin
      bus2.a_stb = 1'b0;
      bus2.b_stb = 1'b0;
    end
    extra = 0;
    early = 0;
    for (int n = 2; n <= 13; n++) begin
      @(negedge clk);
      if (bus2.a_ack || bus2.b_ack) extra++;
      if (n < 13 && bus2.c_stb) early++;
      if (n == 2) check({name, " busy"}, 64'(bus2.busy), 64'd1);
    end
    bus2.a_stb = 1'b0;
    bus2.b_stb = 1'b0;
    check({name, " c_stb at T+13"}, 64'(bus2.c_stb), 64'd1);
    check({name, " early c_stb"}, 64'(early), 64'd0);
    check({name, " extra acks"}, 64'(extra), 64'd0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        elem = bus2.matrix_C[(i*2+j)*16 +: 16];
        check($sformatf("%s C[%0d][%0d]", name, i, j), 64'(elem), 64'(c_next[i][j]));
      end
    check({name, " overflow"}, 64'(bus2.overflow), 64'(ovf_exp));
    c_model = c_next;
    snap = bus2.matrix_C;
    unstable = 0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (bus2.c_stb !== 1'b1 || bus2.matrix_C !== snap || bus2.overflow !== ovf_exp)
        unstable++;
    end
    if (stall > 0) check({name, " hold during stall"}, 64'(unstable), 64'd0);
    bus2.c_ack = 1'b1;
    @(negedge clk);
    bus2.c_ack = 1'b0;
    check({name, " c_stb after ack"}, 64'(bus2.c_stb), 64'd0);
    check({name, " busy after ack"}, 64'(bus2.busy), 64'd0);
    check({name, " overflow retained"}, 64'(bus2.overflow), 64'(ovf_exp));
  endtask

  initial begin
    int bad;
    bus2.matrix_A = '0; bus2.matrix_B = '0; bus2.a_stb = 0; bus2.b_stb = 0;
    bus2.signed_mode = 0; bus2.acc_en = 0; bus2.c_ack = 0;
    bus1.matrix_A = '0; bus1.matrix_B = '0; bus1.a_stb = 0; bus1.b_stb = 0;
    bus1.signed_mode = 0; bus1.acc_en = 0; bus1.c_ack = 0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) c_model[i][j] = 0;
    rst2 = 1'b0;
    rst1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset c_stb", 64'(bus2.c_stb), 64'd0);
    check("reset busy", 64'(bus2.busy), 64'd0);
    check("reset acks", 64'({bus2.a_ack, bus2.b_ack}), 64'd0);
    check("reset overflow", 64'(bus2.overflow), 64'd0);
    check("reset matrix_C", bus2.matrix_C, 64'd0);
    rst2 = 1'b1;
    rst1 = 1'b1;
    @(negedge clk);

    set_ops(1, 2, 3, 4, 1, 0, 0, 1);
    run_job("identity", 1, 0, 0, 0);
    set_ops(255, 2, 3, 252, 5, 6, 7, 8);
    run_job("mixed signed", 1, 0, 0, 0);
    run_job("mixed unsigned", 0, 0, 0, 0);
    run_job("mixed signed again", 1, 0, 0, 0);
    run_job("accumulate", 1, 1, 0, 0);
    set_ops(128, 128, 128, 128, 128, 128, 128, 128);
    run_job("signed saturate", 1, 0, 0, 0);
    set_ops(255, 255, 255, 255, 255, 255, 255, 255);
    run_job("unsigned saturate", 0, 0, 0, 0);

    bus2.a_stb = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus2.a_ack || bus2.b_ack || bus2.busy) bad++;
    end
    bus2.a_stb = 1'b0;
    bus2.b_stb = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus2.a_ack || bus2.b_ack || bus2.busy) bad++;
    end
    bus2.b_stb = 1'b0;
    check("lone strobe ignored", 64'(bad), 64'd0);

    set_ops(7, 250, 3, 9, 11, 2, 200, 5);
    run_job("held strobes stall", 1, 0, 1, 10);

    for (int r = 0; r < 8; r++) begin
      set_ops($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255));
      run_job($sformatf("random %0d", r), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'(r % 2), $urandom_range(0, 3));
    end

    set_ops(9, 9, 9, 9, 9, 9, 9, 9);
    pack_ops();
    bus2.signed_mode = 1'b0;
    bus2.acc_en = 1'b0;
    bus2.a_stb = 1'b1;
    bus2.b_stb = 1'b1;
    @(negedge clk);
    bus2.a_stb = 1'b0;
    bus2.b_stb = 1'b0;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    #1;
    check("mid-job reset c_stb", 64'(bus2.c_stb), 64'd0);
    check("mid-job reset busy", 64'(bus2.busy), 64'd0);
    check("mid-job reset matrix_C", bus2.matrix_C, 64'd0);
    check("mid-job reset overflow", 64'(bus2.overflow), 64'd0);
    @(negedge clk);
    rst2 = 1'b1;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) c_model[i][j] = 0;
    @(negedge clk);
    set_ops(255, 2, 3, 252, 5, 6, 7, 8);
    run_job("after reset accumulate", 1, 1, 0, 0);

    bus1.matrix_A = 8'd3;
    bus1.matrix_B = 8'hFB;
    bus1.signed_mode = 1'b1;
    bus1.a_stb = 1'b1;
    bus1.b_stb = 1'b1;
    @(negedge clk);
    bus1.a_stb = 1'b0;
    bus1.b_stb = 1'b0;
    rst1 = 1'b0;
    #1;
    check("1x1 reset busy", 64'(bus1.busy), 64'd0);
    check("1x1 reset acks", 64'({bus1.a_ack, bus1.b_ack}), 64'd0);
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    bus1.acc_en = 1'b1;
    bus1.a_stb = 1'b1;
    bus1.b_stb = 1'b1;
    @(negedge clk);
    check("1x1 a_ack", 64'(bus1.a_ack), 64'd1);
    bus1.a_stb = 1'b0;
    bus1.b_stb = 1'b0;
    @(negedge clk);
    check("1x1 c_stb at T+2", 64'(bus1.c_stb), 64'd0);
    @(negedge clk);
    check("1x1 c_stb at T+3", 64'(bus1.c_stb), 64'd1);
    check("1x1 result", 64'(bus1.matrix_C), 64'hFFF1);
    check("1x1 overflow", 64'(bus1.overflow), 64'd0);
    bus1.c_ack = 1'b1;
    @(negedge clk);
    bus1.c_ack = 1'b0;
    check("1x1 c_stb after ack", 64'(bus1.c_stb), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
